// File: rtl/bsearch_resolver.sv
// ---------------------------------------------------------------------------
// bsearch_resolver
//
// Recovers a hidden operand held by an external magnitude comparator. Each
// probe is presented on oGuess and the comparator answers with a 3-bit
// relation code (bit2 = probe>hidden, bit1 = probe<hidden, bit0 = equal).
// The block binary-searches the range 0 .. 2^WIDTH-1 until the relation
// says equal, the search interval empties, or an illegal code arrives.
//
// Optional feature macro: BSEARCH_TIMEOUT_EN
//   Defined   -> abort with oError=1 after TIMEOUT consecutive PROBE cycles
//                without iValid.
//   Undefined -> PROBE waits indefinitely for iValid.
//
// Handshake: oGuess_valid=1 means a probe is on oGuess. A result is consumed
// on every cycle where oGuess_valid=1 and iValid=1. There is no
// back-pressure on the answer side; iValid outside PROBE is ignored.
//
// Ports:
//   clk           in   clock, all state on rising edge
//   rst           in   synchronous active-high reset
//   iStart        in   start pulse, honoured in IDLE or DONE
//   iData[2:0]    in   relation of probe vs hidden operand
//   iValid        in   iData valid this cycle
//   oGuess        out  current probe (0 when no probe is presented)
//   oGuess_valid  out  probe presented, awaiting result
//   oData         out  resolved operand (valid with oDone & oFound)
//   oDone         out  search finished, level held
//   oFound        out  operand resolved
//   oError        out  illegal relation code, or timeout
//   oSteps        out  number of accepted probe results
//   o_state       out  FSM state, for observation
// ---------------------------------------------------------------------------
module bsearch_resolver #(
  parameter int WIDTH   = 8,
  parameter int STEPW   = $clog2(WIDTH + 2),
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iStart,
  input  logic [2:0]       iData,
  input  logic             iValid,
  output logic [WIDTH-1:0] oGuess,
  output logic             oGuess_valid,
  output logic [WIDTH-1:0] oData,
  output logic             oDone,
  output logic             oFound,
  output logic             oError,
  output logic [STEPW-1:0] oSteps,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PROBE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH:0] LP_MAX = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0] LP_ONE = {{WIDTH{1'b0}}, 1'b1};

  // lo/hi carry one extra bit so that guess+1 can reach 2^WIDTH and
  // guess-1 can reach -1 without wrapping back into the search range.
  state_t           r_state, w_state_n;
  logic [WIDTH:0]   r_lo, w_lo_n;
  logic [WIDTH:0]   r_hi, w_hi_n;
  logic [WIDTH-1:0] r_data, w_data_n;
  logic             r_found, w_found_n;
  logic             r_error, w_error_n;
  logic [STEPW-1:0] r_steps, w_steps_n;

  logic [WIDTH:0]   w_guess;
  logic [WIDTH:0]   w_lo_inc;
  logic [WIDTH:0]   w_hi_dec;
  logic             w_start;
  logic             w_timeout;

  assign w_guess  = r_lo + ((r_hi - r_lo) >> 1);
  assign w_lo_inc = w_guess + LP_ONE;
  assign w_hi_dec = w_guess - LP_ONE;
  assign w_start  = iStart && (r_state != S_PROBE);

`ifdef BSEARCH_TIMEOUT_EN
  localparam int WAITW = $clog2(TIMEOUT + 1);
  localparam logic [WAITW-1:0] LP_WAIT_LAST = WAITW'(TIMEOUT - 1);

  logic [WAITW-1:0] r_wait;

  // Counts idle PROBE cycles; the TIMEOUT-th idle cycle aborts the search.
  always_ff @(posedge clk) begin
    if (rst || w_start || (r_state != S_PROBE) || iValid) begin
      r_wait <= '0;
    end else begin
      r_wait <= r_wait + 1'b1;
    end
  end

  assign w_timeout = (r_state == S_PROBE) && !iValid && (r_wait == LP_WAIT_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_n = r_state;
    w_lo_n    = r_lo;
    w_hi_n    = r_hi;
    w_data_n  = r_data;
    w_found_n = r_found;
    w_error_n = r_error;
    w_steps_n = r_steps;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (iStart) begin
          w_state_n = S_PROBE;
          w_lo_n    = '0;
          w_hi_n    = LP_MAX;
          w_data_n  = '0;
          w_found_n = 1'b0;
          w_error_n = 1'b0;
          w_steps_n = '0;
        end
      end
      S_PROBE: begin
        if (iValid) begin
          w_steps_n = r_steps + 1'b1;
          case (iData)
            3'b001: begin
              w_data_n  = w_guess[WIDTH-1:0];
              w_found_n = 1'b1;
              w_state_n = S_DONE;
            end
            3'b100: begin
              w_hi_n = w_hi_dec;
              // hi = -1 shows up as the top bit set; lo is never negative.
              if (w_hi_dec[WIDTH] || (r_lo > w_hi_dec)) begin
                w_state_n = S_DONE;
              end
            end
            3'b010: begin
              w_lo_n = w_lo_inc;
              if (w_lo_inc > r_hi) begin
                w_state_n = S_DONE;
              end
            end
            default: begin
              w_error_n = 1'b1;
              w_state_n = S_DONE;
            end
          endcase
        end else if (w_timeout) begin
          w_error_n = 1'b1;
          w_state_n = S_DONE;
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_lo    <= '0;
      r_hi    <= LP_MAX;
      r_data  <= '0;
      r_found <= 1'b0;
      r_error <= 1'b0;
      r_steps <= '0;
    end else begin
      r_state <= w_state_n;
      r_lo    <= w_lo_n;
      r_hi    <= w_hi_n;
      r_data  <= w_data_n;
      r_found <= w_found_n;
      r_error <= w_error_n;
      r_steps <= w_steps_n;
    end
  end

  // The probe is only driven while it is being offered, so the outputs read
  // all-zero in IDLE and DONE.
  assign oGuess       = (r_state == S_PROBE) ? w_guess[WIDTH-1:0] : '0;
  assign oGuess_valid = (r_state == S_PROBE);
  assign oData        = r_data;
  assign oDone        = (r_state == S_DONE);
  assign oFound       = r_found;
  assign oError       = r_error;
  assign oSteps       = r_steps;
  assign o_state      = r_state;

endmodule

// File: tb/tb_bsearch_resolver.sv
module tb_bsearch_resolver;

  logic       clk;
  logic       rst;
  logic       iStart;
  logic [2:0] iData;
  logic       iValid;
  logic [7:0] oGuess;
  logic       oGuess_valid;
  logic [7:0] oData;
  logic       oDone;
  logic       oFound;
  logic       oError;
  logic [3:0] oSteps;
  logic [1:0] o_state;

  int tests;
  int fails;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         stall_bad;

  bsearch_resolver #(.WIDTH(8), .STEPW(4), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .iStart       (iStart),
    .iData        (iData),
    .iValid       (iValid),
    .oGuess       (oGuess),
    .oGuess_valid (oGuess_valid),
    .oData        (oData),
    .oDone        (oDone),
    .oFound       (oFound),
    .oError       (oError),
    .oSteps       (oSteps),
    .o_state      (o_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic pulse_start();
    @(negedge clk);
    iStart = 1'b1;
    @(negedge clk);
    iStart = 1'b0;
  endtask

  // Answers probes until oDone. mode 0: true oracle for 'hidden',
  // mode 1: always 010, mode 2: always 100. 'stall' idle cycles precede
  // every answer; oGuess must hold during them.
  task automatic drive_search(input logic [7:0] hidden, input int mode, input int stall);
    logic [7:0] held;
    int         waited;
    got_q.delete();
    stall_bad = 0;
    waited    = 0;
    held      = oGuess;
    for (int cyc = 0; cyc < 300 && !oDone; cyc++) begin
      if (oGuess_valid) begin
        if (waited == 0) held = oGuess;
        if (oGuess !== held) stall_bad++;
        if (waited < stall) begin
          iValid = 1'b0;
          waited++;
        end else begin
          got_q.push_back(oGuess);
          iValid = 1'b1;
          case (mode)
            1:       iData = 3'b010;
            2:       iData = 3'b100;
            default: iData = (oGuess > hidden) ? 3'b100 :
                             (oGuess < hidden) ? 3'b010 : 3'b001;
          endcase
          waited = 0;
        end
      end
      @(negedge clk);
      iValid = 1'b0;
      iData  = 3'b000;
    end
    tests++;
    if (oDone !== 1'b1) begin
      fails++;
      $display("FAIL search_timeout: oDone=%b, required 1", oDone);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; iStart = 1'b0; iValid = 1'b0; iData = 3'b000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({oGuess, oGuess_valid, oData, oDone, oFound, oError, oSteps} !== '0 || o_state !== 2'd0) begin
      fails++;
      $display("FAIL reset_outputs: guess=%h gv=%b data=%h done=%b found=%b err=%b steps=%0d st=%0d, required all 0",
               oGuess, oGuess_valid, oData, oDone, oFound, oError, oSteps, o_state);
    end
    pulse_start();
    tests++;
    if (oGuess_valid !== 1'b1 || oGuess !== 8'd127) begin
      fails++;
      $display("FAIL first_probe: gv=%b guess=%0d, required 1/127", oGuess_valid, oGuess);
    end
  endtask

  task automatic test_find(input logic [7:0] hidden, input int steps, input string name);
    drive_search(hidden, 0, 0);
    tests++;
    if (got_q != exp_q) begin
      fails++;
      $display("FAIL %s_probes: got %p, required %p", name, got_q, exp_q);
    end
    tests++;
    if (oFound !== 1'b1 || oError !== 1'b0 || oData !== hidden || oSteps !== 4'(steps)) begin
      fails++;
      $display("FAIL %s_result: found=%b err=%b data=%h steps=%0d, required 1/0/%h/%0d",
               name, oFound, oError, oData, oSteps, hidden, steps);
    end
  endtask

  task automatic test_find_5a();
    exp_q = '{8'd127, 8'd63, 8'd95, 8'd79, 8'd87, 8'd91, 8'd89, 8'd90};
    pulse_start();
    test_find(8'h5A, 8, "find_5a");
  endtask

  task automatic test_find_edges();
    exp_q = '{8'd127, 8'd191, 8'd223, 8'd239, 8'd247, 8'd251, 8'd253, 8'd254, 8'd255};
    pulse_start();
    test_find(8'hFF, 9, "find_ff");
    exp_q = '{8'd127};
    pulse_start();
    test_find(8'h7F, 1, "find_7f");
  endtask

  task automatic test_not_found();
    exp_q = '{8'd127, 8'd191, 8'd223, 8'd239, 8'd247, 8'd251, 8'd253, 8'd254, 8'd255};
    pulse_start();
    drive_search(8'h00, 1, 0);
    tests++;
    if (got_q != exp_q || oFound !== 1'b0 || oError !== 1'b0 || oSteps !== 4'd9) begin
      fails++;
      $display("FAIL all_less: probes %p found=%b err=%b steps=%0d, required %p 0/0/9",
               got_q, oFound, oError, oSteps, exp_q);
    end
    exp_q = '{8'd127, 8'd63, 8'd31, 8'd15, 8'd7, 8'd3, 8'd1, 8'd0};
    pulse_start();
    drive_search(8'h00, 2, 0);
    tests++;
    if (got_q != exp_q || oFound !== 1'b0 || oError !== 1'b0 || oSteps !== 4'd8) begin
      fails++;
      $display("FAIL all_greater: probes %p found=%b err=%b steps=%0d, required %p 0/0/8",
               got_q, oFound, oError, oSteps, exp_q);
    end
  endtask

  task automatic test_illegal_and_restart();
    pulse_start();
    iValid = 1'b1; iData = 3'b011;
    @(negedge clk);
    iValid = 1'b0; iData = 3'b000;
    tests++;
    if (oDone !== 1'b1 || oError !== 1'b1 || oFound !== 1'b0 || oSteps !== 4'd1) begin
      fails++;
      $display("FAIL illegal_code: done=%b err=%b found=%b steps=%0d, required 1/1/0/1",
               oDone, oError, oFound, oSteps);
    end
    // iValid in DONE must not disturb the held result.
    iValid = 1'b1; iData = 3'b001;
    @(negedge clk);
    iValid = 1'b0; iData = 3'b000;
    @(negedge clk);
    tests++;
    if (oDone !== 1'b1 || oError !== 1'b1 || oFound !== 1'b0 || oSteps !== 4'd1 || oGuess_valid !== 1'b0) begin
      fails++;
      $display("FAIL done_hold: done=%b err=%b found=%b steps=%0d gv=%b, required 1/1/0/1/0",
               oDone, oError, oFound, oSteps, oGuess_valid);
    end
    exp_q = '{8'd127, 8'd63, 8'd95, 8'd79, 8'd87, 8'd91, 8'd89, 8'd90};
    pulse_start();
    tests++;
    if (oError !== 1'b0 || oDone !== 1'b0 || oSteps !== 4'd0) begin
      fails++;
      $display("FAIL restart_clear: err=%b done=%b steps=%0d, required 0/0/0", oError, oDone, oSteps);
    end
    test_find(8'h5A, 8, "restart_5a");
  endtask

  task automatic test_stall();
    exp_q = '{8'd127, 8'd63, 8'd95, 8'd79, 8'd87, 8'd91, 8'd89, 8'd90};
    pulse_start();
    // iStart while probing must be ignored.
    iStart = 1'b1;
    @(negedge clk);
    iStart = 1'b0;
    drive_search(8'h5A, 0, 5);
    tests++;
    if (stall_bad != 0) begin
      fails++;
      $display("FAIL stall_guess_stable: %0d unstable cycles, required 0", stall_bad);
    end
    tests++;
    if (got_q != exp_q || oFound !== 1'b1 || oData !== 8'h5A || oSteps !== 4'd8) begin
      fails++;
      $display("FAIL stall_result: probes %p found=%b data=%h steps=%0d, required %p 1/5a/8",
               got_q, oFound, oData, oSteps, exp_q);
    end
  endtask

  task automatic test_reset_mid_search();
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      iValid = 1'b1;
      iData  = (oGuess > 8'h5A) ? 3'b100 : 3'b010;
      @(negedge clk);
    end
    iValid = 1'b0; iData = 3'b000;
    tests++;
    if (oSteps !== 4'd3 || oGuess !== 8'd79) begin
      fails++;
      $display("FAIL mid_progress: steps=%0d guess=%0d, required 3/79", oSteps, oGuess);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({oGuess, oGuess_valid, oData, oDone, oFound, oError, oSteps} !== '0 || o_state !== 2'd0) begin
      fails++;
      $display("FAIL mid_reset: guess=%h gv=%b data=%h done=%b found=%b err=%b steps=%0d st=%0d, required all 0",
               oGuess, oGuess_valid, oData, oDone, oFound, oError, oSteps, o_state);
    end
  endtask

`ifdef BSEARCH_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    pulse_start();
    n = 0;
    while (!oDone && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n != 16 || oError !== 1'b1 || oFound !== 1'b0 || oSteps !== 4'd0) begin
      fails++;
      $display("FAIL timeout: cycles=%0d err=%b found=%b steps=%0d, required 16/1/0/0",
               n, oError, oFound, oSteps);
    end
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    test_find_5a();
    test_find_edges();
    test_not_found();
    test_illegal_and_restart();
    test_stall();
    test_reset_mid_search();
`ifdef BSEARCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
